// File: rtl/encoder_8_3_sync_if.sv
// Request/result bundle for the debounced 8:3 priority encoder.
// The master side drives the raw request lines; the slave side returns the published code.
interface encoder_8_3_sync_if;
    logic [7:0] y;
    logic [2:0] a;
    logic       valid;
    logic       strobe;
    logic       error;

    modport master (
        output y,
        input  a,
        input  valid,
        input  strobe,
        input  error
    );

    modport slave (
        input  y,
        output a,
        output valid,
        output strobe,
        output error
    );
endinterface

// File: rtl/encoder_8_3_sync.sv
// Debounced 8:3 priority encoder: synchronizes eight async request lines and publishes a
// pattern only after it has held for STABLE_CYCLES clocks. Optional ENCODER_MULTI_ERR_EN
// builds the multiple-active error flag; otherwise error is tied low.
module encoder_8_3_sync #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    encoder_8_3_sync_if.slave  bus
);
    localparam int unsigned LINES = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    logic [LINES-1:0]  sync_q1;
    logic [LINES-1:0]  sync_q2;
    logic [LINES-1:0]  sync_prev_q;
    logic [LINES-1:0]  pub_q;
    logic [CNT_W-1:0]  cnt_q;
    state_t            state_q;
    logic [CODE_W-1:0] a_q;
    logic              valid_q;
    logic              strobe_q;

    logic [CNT_W-1:0]  cnt_nxt_c;
    logic              publish_c;
    logic [CODE_W-1:0] code_c;
    logic              strobe_nxt_c;

    // Index of the highest set bit; all-zero maps to code 0.
    function automatic logic [CODE_W-1:0] prio_code(input logic [LINES-1:0] p);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < LINES; i++) begin
            if (p[i]) c = CODE_W'(i);
        end
        return c;
    endfunction

    // Two-flop synchronizer plus one extra stage holding the previous synchronized value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q1     <= bus.y;
            sync_q2     <= sync_q1;
            sync_prev_q <= sync_q2;
        end
    end

    // Stability count restarts on any change of the synchronized vector and saturates.
    always_comb begin
        cnt_nxt_c = cnt_q;
        if (sync_q2 != sync_prev_q) begin
            cnt_nxt_c = '0;
        end else if (cnt_q >= CNT_SAT) begin
            cnt_nxt_c = CNT_SAT;
        end else begin
            cnt_nxt_c = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        publish_c    = 1'b0;
        code_c       = prio_code(sync_q2);
        strobe_nxt_c = 1'b0;
        if ((state_q == SETTLE) && (cnt_nxt_c == CNT_SAT) && (sync_q2 != pub_q)) begin
            publish_c = 1'b1;
        end
        // Strobe only for a genuinely new nonzero code, not for lower-priority churn.
        if (publish_c && (|sync_q2) && (!valid_q || (code_c != a_q))) begin
            strobe_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pub_q    <= '0;
            a_q      <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_nxt_c;
            strobe_q <= strobe_nxt_c;
            case (state_q)
                IDLE, HOLD: begin
                    if (sync_q2 != pub_q) state_q <= SETTLE;
                end
                SETTLE: begin
                    if (publish_c) begin
                        state_q <= (|sync_q2) ? HOLD : IDLE;
                    end else if (sync_q2 == pub_q) begin
                        state_q <= (|pub_q) ? HOLD : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (publish_c) begin
                pub_q   <= sync_q2;
                a_q     <= code_c;
                valid_q <= |sync_q2;
            end
        end
    end

`ifdef ENCODER_MULTI_ERR_EN
    logic error_q;
    logic multi_c;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    always_comb begin
        multi_c = |(sync_q2 & (sync_q2 - LINES'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (publish_c) begin
            error_q <= multi_c;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.a      = a_q;
    assign bus.valid  = valid_q;
    assign bus.strobe = strobe_q;
endmodule

// File: doc/encoder_8_3_sync.md
ENCODER_8_3_SYNC -- requirements
Module: encoder_8_3_sync

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive clocks a synchronized input pattern must hold unchanged before it is published (legal range 1..255).
REQ-002 Clk  input  1  system clock, all state on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Y0..Y7  input  1 each  asynchronous request lines, active-high, Y7 highest priority.
REQ-005 A0..A2  output  1 each  registered binary code of highest-priority published active line, A2 = MSB.
REQ-006 Valid  output  1  registered; 1 while published pattern has at least one active line.
REQ-007 Strobe  output  1  registered one-cycle pulse when a new published code becomes valid.
REQ-008 Error  output  1  registered multiple-active flag (see Configuration).

Function
REQ-009 Each Yn SHALL pass through a two-flop synchronizer; only the second-stage vector S[7:0] is used downstream.
REQ-010 A stability counter SHALL reset to 0 on any edge where S differs from its value on the previous edge, and otherwise increment, saturating at STABLE_CYCLES.
REQ-011 The state machine SHALL have states IDLE (published pattern all-zero), SETTLE (S differs from published pattern, counter below STABLE_CYCLES), HOLD (published pattern nonzero and equal to S).
REQ-012 Transitions: IDLE->SETTLE and HOLD->SETTLE when S differs from published; SETTLE->HOLD on publish of nonzero pattern; SETTLE->IDLE on publish of all-zero pattern; SETTLE->IDLE/HOLD without publish if S returns to the published pattern before counter saturates.
REQ-013 Publish SHALL occur on the edge where the counter reaches STABLE_CYCLES and S differs from the published pattern; A2..A0, Valid, Error update on that same edge.
REQ-014 Encoding SHALL be strict priority: A = index of highest set bit of published pattern; all-zero pattern gives A=000, Valid=0.
REQ-015 Strobe SHALL be 1 for exactly one cycle on a publish whose pattern is nonzero and whose code differs from the previously published code or follows Valid=0; no Strobe when only lower-priority bits change.
REQ-016 Latency: a clean input step SHALL reach the outputs STABLE_CYCLES+2 rising edges after the edge that first samples it.
REQ-017 Any S change during SETTLE SHALL restart the count; glitches shorter than STABLE_CYCLES clocks SHALL never reach outputs.
REQ-018 Outputs SHALL remain constant between publishes, including while in SETTLE.

Reset
REQ-019 Reset SHALL asynchronously force synchronizers, counter, published pattern to 0, state to IDLE, A2..A0=000, Valid=0, Strobe=0, Error=0.
REQ-020 Reset asserted mid-SETTLE SHALL discard the pending pattern; after release, a held input is republished after full latency with Strobe.

Configuration
REQ-021 Macro ENCODER_MULTI_ERR_EN: when defined, Error SHALL be 1 while the published pattern has two or more bits set, updated at publish; when undefined, Error SHALL be tied 0 and the detection logic SHALL not be built.

Verification
REQ-022 Reset, all Y=0 -> A=000, Valid=0, Strobe=0, Error=0 in IDLE.
REQ-023 Raise Y5 and hold (STABLE_CYCLES=4) -> on 6th edge after first sample A=101, Valid=1, Strobe single pulse; release Y5 -> 6 edges later Valid=0, A=000, no Strobe.
REQ-024 Pulse Y7 for 2 clocks while Y2 held and published -> outputs stay A=010, no Strobe.
REQ-025 Hold Y3, then add Y1 -> publish with A=011 unchanged, no Strobe; Error=1 only with ENCODER_MULTI_ERR_EN defined, else 0.
REQ-026 Walk Y0..Y7 singly, each held 10 clocks -> A follows 000..111, eight Strobe pulses, Error=0.
REQ-027 Assert Reset 2 cycles into SETTLE with Y6 held -> outputs 0 immediately; after release A=110, Valid=1, one Strobe after full latency.
